sysid_probe_master: RTL and testbench
=====================================

Name: sysid_probe_master

Overview:
- Avalon-MM read master for the 1-bit-address system-ID control slave.
- Reads word 0 (system ID) and then word 1 (build timestamp) over a 32-bit readdata bus. Compares both against build-time expected values and reports pass/fail.
- Sits between the boot/health-check logic and the system-ID slave. Lets hardware verify the loaded image before releasing the multicore image-processing pipeline.

Parameters:
- EXPECTED_ID, 32'd34566365, value required at address 0.
- EXPECTED_TS, 32'd1568289510, value required at address 1.
- TIMEOUT_CYCLES, 255, maximum cycles one read may stall on waitrequest before it counts as failed; must be ≥1.
- MAX_RETRIES, 3, extra attempts allowed per word after a timeout; 0 means no retry.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a probe; ignored while busy=1.
- avm_address  out  1  0 = system ID, 1 = timestamp.
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave.
- avm_readdata  in  32  slave read data, valid in the cycle where avm_read=1 and avm_waitrequest=0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the probe finishes.
- pass  out  1  sticky result: id_match & ts_match & ~timeout_err.
- id_match  out  1  sticky: captured ID equals EXPECTED_ID.
- ts_match  out  1  sticky: captured timestamp equals EXPECTED_TS.
- timeout_err  out  1  sticky: a word exhausted all of its retries.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

Behaviour:
- Reset: every output is 0; state is IDLE; the timer and retry count are 0.
- Reset asserted mid-probe: the transaction is abandoned on the next edge and no done pulse is issued.
- States and transitions:
  - IDLE: on start=1, go to RD_ID. Clear pass, id_match, ts_match and timeout_err. Load retry count with MAX_RETRIES. Clear the timer.
  - RD_ID: drive avm_read=1, avm_address=0. Address and read are held stable while waitrequest=1.
    - If waitrequest=0: capture readdata into id_value, reload the retry count, clear the timer, go to RD_TS.
    - If the timer reaches TIMEOUT_CYCLES while waitrequest is still 1: drop avm_read for exactly one cycle (state RETRY), then reissue the read.
    - A timeout is counted only while the retry count is nonzero; that count is decremented.
    - On a timeout with retry count 0: set timeout_err and go to CHECK.
  - RD_TS: same rules as RD_ID, but with address 1 and capture into ts_value.
  - RETRY: avm_read=0 for one cycle, then return to the state that was active before it. This needs a 1-bit return tag.
  - CHECK: one cycle. Register id_match and ts_match from the captured values. A word that was never captured gives a 0 match. Register pass. Go to DONE.
  - DONE: done=1 for one cycle, busy=0 from this cycle, return to IDLE.
- Latency with a zero-wait slave: start at cycle 0; RD_ID at cycle 1; RD_TS at cycle 2; CHECK at cycle 3; done at cycle 4.
- Timer rules:
  - The timer increments on each cycle where avm_read=1 and waitrequest=1.
  - A read with waitrequest=0 is accepted in the same cycle, regardless of the timer value.
  - A transfer is accepted at stall count ≤ TIMEOUT_CYCLES−1. A timeout fires on the cycle the count equals TIMEOUT_CYCLES.
  - The timer width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wraps.
- Results stay stable until the next accepted start.
- start in the same cycle as done is ignored; start is accepted only in IDLE.
- avm_read is never asserted in IDLE, CHECK or DONE.

Decomposition:
- Package sysid_probe_pkg holds:
  - the state enum {IDLE, RD_ID, RD_TS, RETRY, CHECK, DONE};
  - the address constants ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - a function returning the timer width.
- One sub-module, sysid_probe_timer: a saturating stall counter.
  - Inputs: clear, enable.
  - Output: expired, asserted when count == TIMEOUT_CYCLES.
- The FSM, capture registers and compare logic stay in the top module.

Test Plan:
- Zero-wait slave model returning 34566365 and 1568289510, start pulse at cycle 0 → done at cycle 4, pass=1, id_value=34566365, ts_value=1568289510.
- Slave returns 0x12345678 at address 0 → id_match=0, ts_match=1, pass=0, done issued.
- waitrequest held 3 cycles on each read → address and read stay stable during the stall, done at cycle 10, pass=1.
- waitrequest stuck at 1 on address 1, TIMEOUT_CYCLES=4, MAX_RETRIES=1 → two 4-cycle attempts with a one-cycle avm_read=0 gap between them, then timeout_err=1, ts_match=0, pass=0, done issued.
- reset asserted during RD_TS → all outputs 0 on the next edge, no done pulse; a following start completes normally with pass=1.
- start pulses while busy, and start coinciding with done → ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
package sysid_probe_pkg;

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, RETRY, CHECK, DONE} state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Counter must be able to hold TIMEOUT_CYCLES itself so it can saturate there.
  function automatic int timer_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only link between the probe master and the system-ID slave.
interface sysid_probe_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/sysid_probe_timer.sv
// Saturating stall counter; expired holds once the count reaches TIMEOUT_CYCLES.
module sysid_probe_timer
  import sysid_probe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear)                count <= '0;
    else if (enable && count != LIMIT) count <= count + W'(1);
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sysid_probe_master.sv
// Reads system ID then build timestamp, compares against build-time values,
// and reports a sticky pass/fail with per-word retry on waitrequest timeout.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd34566365,
  parameter logic [31:0] EXPECTED_TS    = 32'd1568289510,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  sysid_probe_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        id_match,
  output logic                        ts_match,
  output logic                        timeout_err,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  state_e        state, nstate;
  logic [RW-1:0] retry_cnt;
  logic          ret_ts;
  logic          id_got, ts_got;
  logic          in_rd, accept, expired, tmo;

  assign in_rd  = (state == RD_ID) || (state == RD_TS);
  assign accept = in_rd && !avm.avm_waitrequest;
  // Acceptance wins over an expired timer in the same cycle.
  assign tmo    = in_rd && avm.avm_waitrequest && expired;

  sysid_probe_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_rd || accept || tmo),
    .enable  (in_rd && avm.avm_waitrequest),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:          if (start) nstate = RD_ID;
      RD_ID, RD_TS: begin
        if (accept)   nstate = (state == RD_ID) ? RD_TS : CHECK;
        else if (tmo) nstate = (retry_cnt != '0) ? RETRY : CHECK;
      end
      RETRY:         nstate = ret_ts ? RD_TS : RD_ID;
      CHECK:         nstate = DONE;
      DONE:          nstate = IDLE;
      default:       nstate = IDLE;
    endcase
  end

  always_comb begin
    avm.avm_read    = in_rd;
    avm.avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
    busy            = in_rd || (state == RETRY) || (state == CHECK);
    done            = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt   <= '0;
      ret_ts      <= 1'b0;
      id_got      <= 1'b0;
      ts_got      <= 1'b0;
      pass        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          retry_cnt   <= RW'(MAX_RETRIES);
          id_got      <= 1'b0;
          ts_got      <= 1'b0;
          pass        <= 1'b0;
          id_match    <= 1'b0;
          ts_match    <= 1'b0;
          timeout_err <= 1'b0;
        end
        RD_ID, RD_TS: begin
          if (accept) begin
            retry_cnt <= RW'(MAX_RETRIES);
            if (state == RD_ID) begin
              id_value <= avm.avm_readdata;
              id_got   <= 1'b1;
            end else begin
              ts_value <= avm.avm_readdata;
              ts_got   <= 1'b1;
            end
          end else if (tmo) begin
            if (retry_cnt != '0) begin
              retry_cnt <= retry_cnt - RW'(1);
              ret_ts    <= (state == RD_TS);
            end else begin
              timeout_err <= 1'b1;
            end
          end
        end
        // A word that was never captured must not match, even if a stale value equals the target.
        CHECK: begin
          id_match <= id_got && (id_value == EXPECTED_ID);
          ts_match <= ts_got && (ts_value == EXPECTED_TS);
          pass     <= id_got && (id_value == EXPECTED_ID) &&
                      ts_got && (ts_value == EXPECTED_TS) && !timeout_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Directed bench for sysid_probe_master with a short timeout and one retry.
module tb_sysid_probe_master;
  localparam logic [31:0] EXP_ID = 32'd34566365;
  localparam logic [31:0] EXP_TS = 32'd1568289510;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        busy, done, pass, id_match, ts_match, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        wr, stuck_ts;
  logic [31:0] id_word, ts_word;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt;

  sysid_probe_master_if bus ();

  assign bus.avm_waitrequest = wr | (stuck_ts & bus.avm_address);
  assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

  sysid_probe_master #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(4), .MAX_RETRIES(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .avm(bus.master),
    .busy(busy), .done(done), .pass(pass), .id_match(id_match), .ts_match(ts_match),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {25'd0, busy, done, pass, id_match, ts_match, timeout_err, bus.avm_read}, 32'd0);
    chk({tag, "_id"}, id_value, 32'd0);
    chk({tag, "_ts"}, ts_value, 32'd0);
  endtask

  // Pulses start in cycle 0 and leaves the bench in cycle 1.
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr = 1'b0; stuck_ts = 1'b0;
    id_word = EXP_ID; ts_word = EXP_TS;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Zero-wait slave, matching words
    kick();
    chk("t1_c1_read", bus.avm_read, 1); chk("t1_c1_addr", bus.avm_address, 0);
    chk("t1_c1_busy", busy, 1);
    step();
    chk("t1_c2_read", bus.avm_read, 1); chk("t1_c2_addr", bus.avm_address, 1);
    step();
    chk("t1_c3_read", bus.avm_read, 0); chk("t1_c3_done", done, 0);
    step();
    chk("t1_c4_done", done, 1); chk("t1_c4_busy", busy, 0);
    chk("t1_pass", pass, 1); chk("t1_idv", id_value, EXP_ID); chk("t1_tsv", ts_value, EXP_TS);
    step();
    chk("t1_c5_done", done, 0); chk("t1_c5_pass_sticky", pass, 1);

    // Wrong system ID
    id_word = 32'h12345678;
    step();
    kick(); step(); step(); step();
    chk("t2_done", done, 1); chk("t2_idm", id_match, 0); chk("t2_tsm", ts_match, 1);
    chk("t2_pass", pass, 0); chk("t2_idv", id_value, 32'h12345678);
    id_word = EXP_ID;
    step();

    // Three-cycle stall on each read
    kick();
    for (int c = 1; c <= 10; c++) begin
      wr = (c <= 3) || (c >= 5 && c <= 7);
      #1;
      if (c <= 8) begin
        chk($sformatf("t3_c%0d_read", c), bus.avm_read, 1);
        chk($sformatf("t3_c%0d_addr", c), bus.avm_address, (c >= 5) ? 1 : 0);
      end
      if (c == 9)  chk("t3_c9_read", bus.avm_read, 0);
      if (c < 10)  chk($sformatf("t3_c%0d_done", c), done, 0);
      if (c == 10) begin
        chk("t3_done", done, 1); chk("t3_pass", pass, 1);
      end
      if (c < 10) step();
    end
    wr = 1'b0;
    step();

    // Timestamp read stuck: two attempts, one-cycle gap, then timeout
    stuck_ts = 1'b1;
    kick();
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("t4_c%0d_read", c), bus.avm_read,
          ((c <= 6) || (c >= 8 && c <= 12)) ? 1 : 0);
      if (c >= 2 && c <= 12 && c != 7) chk($sformatf("t4_c%0d_addr", c), bus.avm_address, 1);
      if (c < 14) chk($sformatf("t4_c%0d_done", c), done, 0);
      if (c < 14) step();
    end
    chk("t4_done", done, 1); chk("t4_terr", timeout_err, 1); chk("t4_tsm", ts_match, 0);
    chk("t4_idm", id_match, 1); chk("t4_pass", pass, 0);
    stuck_ts = 1'b0;
    step();

    // Reset during RD_TS abandons the probe
    kick(); step();
    chk("t5_in_rdts", bus.avm_address, 1);
    reset = 1'b1;
    step();
    chk_all_zero("t5_rst");
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_cnt++;
      step();
    end
    chk("t5_no_done", done_cnt, 0);
    kick(); step(); step(); step();
    chk("t5_done", done, 1); chk("t5_pass", pass, 1);
    step();

    // start held through busy and into done: one probe only
    start = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done) done_cnt++;
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t6_idle_busy%0d", c), busy, 0);
      step();
      if (done) done_cnt++;
    end
    chk("t6_done_cnt", done_cnt, 1); chk("t6_pass", pass, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
